// File: rtl/bram_pkg.sv
// Shared constants for the BRAM read arbiter slice, plus a one-hot to index
// encoder used by the round-robin picker.
package bram_pkg;

    localparam int AW    = 5;
    localparam int DW    = 13;
    localparam int DEPTH = 32;

    // OR-encoder: only meaningful for a one-hot (or all-zero) vector
    function automatic int unsigned onehot_to_idx(input logic [7:0] oh);
        int unsigned idx;
        idx = 32'd0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (oh[i]) begin
                idx = idx | i;
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/bram_rd_arb_if.sv
// Requester-side bus of the BRAM read arbiter: request/address in,
// one-hot grant plus registered response out.
interface bram_rd_arb_if
    import bram_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = bram_pkg::AW,
    parameter int DW   = bram_pkg::DW
);

    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_data;

    modport master (
        output req,
        output req_addr,
        input  gnt,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req,
        input  req_addr,
        output gnt,
        output rsp_valid,
        output rsp_data
    );

endinterface

// File: rtl/bram_rd_arb_rr_pick.sv
// Round-robin picker: first asserted request at or after last_gnt+1, wrapping
// modulo NREQ. Pure combinational.
module rr_pick
    import bram_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_gnt,
    output logic [NREQ-1:0] pick,
    output logic [IW-1:0]   pick_idx
);

    logic [IW-1:0] idx_s;
    logic          found_s;

    // walk the NREQ candidates in priority order, keep the first hit
    always_comb begin
        pick    = '0;
        found_s = 1'b0;
        idx_s   = last_gnt;
        for (int k = 0; k < NREQ; k++) begin
            if (idx_s == IW'(NREQ - 1)) begin
                idx_s = '0;
            end else begin
                idx_s = idx_s + IW'(1);
            end
            if (!found_s && req[idx_s]) begin
                pick[idx_s] = 1'b1;
                found_s     = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign pick_idx = IW'(onehot_to_idx(8'(pick)));

endmodule

// File: rtl/bram_rd_arb.sv
// Round-robin arbiter sharing one BRAM read port among NREQ requesters, with
// read-after-write stall when the winner's address is being written.
module bram_rd_arb
    import bram_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = bram_pkg::AW,
    parameter int DW   = bram_pkg::DW
) (
    input  logic                clk,
    input  logic                rst_n,
    bram_rd_arb_if.slave        bus,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [DW-1:0]       wr_data,
    output logic                ram_rd_en,
    output logic [AW-1:0]       ram_rd_addr,
    input  logic [DW-1:0]       ram_rd_data
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IW-1:0]   last_gnt_r;
    logic [NREQ-1:0] rsp_valid_r;
    logic [15:0]     hit_cnt_r;

    logic [NREQ-1:0] pick_s;
    logic [IW-1:0]   pick_idx_s;
    logic [AW-1:0]   win_addr_s;
    logic            hazard_s;
    logic [NREQ-1:0] gnt_s;
    logic            unused_wr_data_s;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req      (bus.req),
        .last_gnt (last_gnt_r),
        .pick     (pick_s),
        .pick_idx (pick_idx_s)
    );

    // address of the would-be winner; AND-OR mux so it is 0 with no pick
    always_comb begin
        win_addr_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_s[i]) begin
                win_addr_s = win_addr_s | bus.req_addr[i*AW +: AW];
            end else begin
                win_addr_s = win_addr_s;
            end
        end
    end

    // a stalled winner keeps last_gnt, so it stays first in line next cycle
    always_comb begin
        hazard_s = 1'b0;
        gnt_s    = '0;
        if (wr_en && (|pick_s) && (wr_addr == win_addr_s)) begin
            hazard_s = 1'b1;
        end else begin
            hazard_s = 1'b0;
        end
        if (rst_n && !hazard_s) begin
            gnt_s = pick_s;
        end else begin
            gnt_s = '0;
        end
    end

    assign bus.gnt       = gnt_s;
    assign ram_rd_en     = |gnt_s;
    assign ram_rd_addr   = ram_rd_en ? win_addr_s : '0;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_data  = ram_rd_data;

    // write data only matters to the RAM itself; hazards compare addresses
    assign unused_wr_data_s = ^wr_data;

    // arbitration state, response strobe and stall counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_r  <= IW'(NREQ - 1);
            rsp_valid_r <= '0;
            hit_cnt_r   <= 16'd0;
        end else begin
            rsp_valid_r <= gnt_s;
            if (|gnt_s) begin
                last_gnt_r <= pick_idx_s;
            end else begin
                last_gnt_r <= last_gnt_r;
            end
            if (hazard_s) begin
                hit_cnt_r <= hit_cnt_r + 16'd1;
            end else begin
                hit_cnt_r <= hit_cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_bram_rd_arb.sv
// Bench for bram_rd_arb: directed scenarios plus randomized traffic against a
// cycle-level round-robin reference model and a table-backed RAM model.
module tb_bram_rd_arb;

    localparam int NREQ = 4;
    localparam int AW   = 5;
    localparam int DW   = 13;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          ram_rd_en;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_rd_data;

    bram_rd_arb_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    bram_rd_arb #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .ram_rd_en   (ram_rd_en),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0]      tbl [32];
    int                 m_last;
    int                 m_hits;
    logic [NREQ-1:0]    pend_v;
    logic [DW-1:0]      pend_d;
    logic               rd_en_c;
    logic [AW-1:0]      rd_addr_c;
    int                 wait_c  [NREQ];
    int                 stall_c [NREQ];
    logic [NREQ-1:0]    rq;
    logic [NREQ*AW-1:0] ra;
    logic [NREQ-1:0]    g;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_last  = NREQ - 1;
        m_hits  = 0;
        pend_v  = '0;
        pend_d  = '0;
        rd_en_c = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            wait_c[i]  = 0;
            stall_c[i] = 0;
        end
    endtask

    function automatic int rr_winner(input logic [NREQ-1:0] r, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (((32'(r) >> ((last + k) % NREQ)) & 32'd1) != 32'd0) begin
                return (last + k) % NREQ;
            end
        end
        return -1;
    endfunction

    // One clock cycle: drive inputs, compare against the model, advance.
    task automatic step(input logic [NREQ-1:0] r, input logic [NREQ*AW-1:0] a,
                        input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        output logic [NREQ-1:0] eg);
        int            w;
        logic          hz;
        logic [AW-1:0] eaddr;
        bus.req      = r;
        bus.req_addr = a;
        wr_en        = we;
        wr_addr      = wa;
        wr_data      = wd;
        #1;
        w     = rr_winner(r, m_last);
        eg    = '0;
        eaddr = '0;
        hz    = 1'b0;
        if (w >= 0) begin
            hz = we && (wa == a[w*AW +: AW]);
            if (!hz) begin
                eg    = NREQ'(1 << w);
                eaddr = a[w*AW +: AW];
            end
        end
        check_eq("gnt", 32'(bus.gnt), 32'(eg));
        check_eq("ram_rd_en", 32'(ram_rd_en), 32'(eg != '0));
        check_eq("ram_rd_addr", 32'(ram_rd_addr), 32'(eaddr));
        check_eq("rsp_valid", 32'(bus.rsp_valid), 32'(pend_v));
        if (pend_v != '0) begin
            check_eq("rsp_data", 32'(bus.rsp_data), 32'(pend_d));
        end
        for (int i = 0; i < NREQ; i++) begin
            if (r[i]) begin
                if (eg[i]) begin
                    check_eq("wait_bound", 32'(wait_c[i] - stall_c[i] < NREQ), 32'd1);
                    wait_c[i]  = 0;
                    stall_c[i] = 0;
                end else begin
                    wait_c[i]++;
                    if (hz) stall_c[i]++;
                end
            end else begin
                wait_c[i]  = 0;
                stall_c[i] = 0;
            end
        end
        if (hz) m_hits++;
        if (eg != '0) m_last = w;
        pend_v    = eg;
        pend_d    = tbl[eaddr];
        rd_en_c   = ram_rd_en;
        rd_addr_c = ram_rd_addr;
        @(posedge clk);
        @(negedge clk);
        ram_rd_data = rd_en_c ? tbl[rd_addr_c] : '0;
        if (we) tbl[wa] = wd;
    endtask

    initial begin
        rst_n        = 1'b0;
        wr_en        = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;
        ram_rd_data  = '0;
        bus.req      = 4'b1111;
        bus.req_addr = {5'd13, 5'd12, 5'd11, 5'd10};
        for (int i = 0; i < 32; i++) tbl[i] = DW'(i * 37 + 5);
        tbl[7] = 13'h0AA;
        model_reset();

        // reset state with all requests asserted
        #1;
        check_eq("rst_gnt", 32'(bus.gnt), 32'd0);
        check_eq("rst_ram_rd_en", 32'(ram_rd_en), 32'd0);
        check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("rst_hit_cnt", 32'(dut.hit_cnt_r), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // all four requesting: 0,1,2,3,0
        repeat (5) step(4'b1111, {5'd13, 5'd12, 5'd11, 5'd10}, 1'b0, '0, '0, g);
        step('0, '0, 1'b0, '0, '0, g);

        // lone requester granted back to back
        repeat (3) step(4'b0100, {5'd0, 5'd20, 5'd0, 5'd0}, 1'b0, '0, '0, g);
        step('0, '0, 1'b0, '0, '0, g);

        // RAW hazard on address 7
        step(4'b0010, {5'd0, 5'd0, 5'd7, 5'd0}, 1'b1, 5'd7, 13'h155, g);
        check_eq("raw_no_gnt", 32'(g), 32'd0);
        check_eq("raw_hit_cnt", 32'(dut.hit_cnt_r), 32'd1);
        step(4'b0010, {5'd0, 5'd0, 5'd7, 5'd0}, 1'b0, '0, '0, g);
        check_eq("raw_regrant", 32'(g), 32'b0010);
        check_eq("raw_pend_data", 32'(pend_d), 32'h155);
        step('0, '0, 1'b0, '0, '0, g);

        // write to a different address does not stall
        step(4'b1000, {5'd9, 5'd0, 5'd0, 5'd0}, 1'b1, 5'd3, 13'h1234, g);
        check_eq("nohaz_gnt", 32'(g), 32'b1000);
        step('0, '0, 1'b0, '0, '0, g);

        // reset right after a grant discards the pending response
        step(4'b0001, {5'd0, 5'd0, 5'd0, 5'd10}, 1'b0, '0, '0, g);
        rst_n   = 1'b0;
        bus.req = 4'b1111;
        #1;
        check_eq("rst2_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("rst2_gnt", 32'(bus.gnt), 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("rst2_rsp_valid_hold", 32'(bus.rsp_valid), 32'd0);
        check_eq("rst2_ram_rd_en", 32'(ram_rd_en), 32'd0);
        rst_n       = 1'b1;
        ram_rd_data = '0;
        model_reset();
        step(4'b1010, {5'd4, 5'd0, 5'd6, 5'd0}, 1'b0, '0, '0, g);
        check_eq("post_rst_first", 32'(g), 32'b0010);

        // randomized traffic: requests held until granted, occasional drops
        rq = g ^ g;
        rq = 4'b1000;
        ra = {5'd4, 15'd0};
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!rq[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        rq[i]          = 1'b1;
                        ra[i*AW +: AW] = AW'($urandom_range(0, 11));
                    end
                end else if ($urandom_range(0, 49) == 0) begin
                    rq[i] = 1'b0;
                end
            end
            step(rq, ra, ($urandom_range(0, 2) == 0), AW'($urandom_range(0, 11)), DW'($urandom), g);
            rq = rq & ~g;
        end
        step('0, '0, 1'b0, '0, '0, g);
        check_eq("final_hit_cnt", 32'(dut.hit_cnt_r), 32'(16'(m_hits)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bram_rd_arb.md
BRAM_RD_ARB -- requirements
Module: bram_rd_arb

Interface
REQ-001 Parameters SHALL be: NREQ, default 4, number of read requesters (2..8); AW, default 5, address width (32-entry table); DW, default 13, data width.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req  input  NREQ  per-requester read request; held high with address stable until granted.
REQ-005 req_addr  input  NREQ*AW  packed read addresses; requester i occupies bits [i*AW +: AW].
REQ-006 gnt  output  NREQ  one-hot grant; combinational from req, state and write port.
REQ-007 rsp_valid  output  NREQ  one-hot, registered; marks returned data for requester i.
REQ-008 rsp_data  output  DW  read data shared by all requesters; qualified by rsp_valid.
REQ-009 wr_en, wr_addr, wr_data  input  1/AW/DW  table write, observed for hazard detection only.
REQ-010 ram_rd_en, ram_rd_addr  output  1/AW  to the shared RAM read port; ram_rd_en equals OR of gnt.
REQ-011 ram_rd_data  input  DW  RAM read data, valid one cycle after ram_rd_en; RAM returns 0 when not enabled.

Function
REQ-012 At most one gnt bit SHALL be high per cycle; gnt[i] SHALL only be high when req[i] is high.
REQ-013 Arbitration SHALL be round-robin: search starts at index last_gnt+1 mod NREQ, wrapping; last_gnt updates only on a grant.
REQ-014 After reset last_gnt SHALL be NREQ-1, so requester 0 has top priority first.
REQ-015 ram_rd_addr SHALL equal req_addr of the granted requester; it is 0 when no grant.
REQ-016 Read latency SHALL be one cycle: gnt[i] in cycle N gives rsp_valid[i]=1 and rsp_data=ram_rd_data in cycle N+1.
REQ-017 rsp_data SHALL pass through the incoming ram_rd_data combinationally in the response cycle; rsp_valid SHALL be a registered copy of gnt.
REQ-018 RAW hazard: if wr_en=1 and wr_addr equals the address of the requester that would win, the arbiter SHALL issue no grant that cycle and SHALL leave last_gnt unchanged.
REQ-019 The blocked requester SHALL win in the next hazard-free cycle, ahead of lower-priority requesters, so it reads the newly written value.
REQ-020 Fairness: with no hazards, any asserted req SHALL be granted within NREQ cycles.
REQ-021 A requester that drops req before its grant SHALL get no grant and no response; no error is signalled.
REQ-022 Back-to-back grants SHALL be supported; the same requester may be granted in consecutive cycles only when no other req is high.
REQ-023 A hit counter hit_cnt (16 bits, internal, wraps at 0xFFFF to 0) SHALL count RAW-hazard stall cycles, for debug visibility.

Reset
REQ-024 While rst_n=0, rsp_valid SHALL be 0 and last_gnt SHALL be NREQ-1; hit_cnt SHALL be 0; gnt and ram_rd_en SHALL be 0 regardless of req.
REQ-025 A response pending when reset asserts SHALL be discarded; the first grant after reset release follows REQ-014.

Structure
REQ-026 AW, DW and DEPTH=32 SHALL live in shared package bram_pkg, together with a function for one-hot-to-index conversion.
REQ-027 Round-robin selection SHALL be one sub-module, rr_pick, with inputs req and last_gnt and outputs a one-hot pick and its index.
REQ-028 The design SHALL use no clock gating and no latches.

Verification
REQ-029 Reset, then req=4'b1111 held with distinct addresses -> grants 0,1,2,3,0 in consecutive cycles; each rsp_valid follows one cycle later with the matching table entry.
REQ-030 Only req[2] high for 3 cycles -> gnt[2] for 3 consecutive cycles; 3 responses.
REQ-031 Preload addr 7 = 0x0AA; in one cycle write 0x155 to addr 7 while req[1] (addr 7) would win -> no grant, hit_cnt=1; next cycle gnt[1]; response 0x155.
REQ-032 Write to addr 3 while the winner reads addr 9 -> no stall; grant proceeds normally.
REQ-033 Assert rst_n=0 in the cycle after a grant -> rsp_valid stays 0; after release with req=4'b1010 -> first grant is requester 1.
REQ-034 Random req/addr/write traffic for 10k cycles -> scoreboard: one-hot gnt, every grant answered once, correct data against a reference table, maximum wait within NREQ plus hazard cycles.
